seg_msg_sequencer: RTL and testbench



---
 rtl/seg_msg_sequencer.sv | 127 ++++++++++++
 tb/tb_seg_msg_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_msg_sequencer.sv
// Message sequencer feeding the 7-segment decoder: buffers up to DEPTH codes and plays them back.
// Optional build macro SEG_MSG_LOOP_EN: repeat the message until stop/clear/reset instead of one pass.
module seg_msg_sequencer #(
  parameter int DEPTH  = 8,
  parameter int DWELL  = 4,
  parameter int CODE_W = 6,
  parameter int BLANK  = 63
) (
  input  logic                       clk_2,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [CODE_W-1:0]          wr_data,
  input  logic                       start,
  input  logic                       stop,
  output logic [CODE_W-1:0]          code_out,
  output logic [$clog2(DEPTH)-1:0]   idx,
  output logic                       busy,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       done
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t              state;
  logic [CODE_W-1:0]   msg_buf [DEPTH];
  logic [IW-1:0]       slot;
  logic [DW-1:0]       dwell_cnt;
  logic                wr_ok;
  logic                dwell_last;
  logic                slot_last;

  assign full       = (count == CW'(DEPTH));
  assign wr_ok      = wr_en && !clear && (state == IDLE) && !full;
  assign dwell_last = (dwell_cnt == DW'(DWELL - 1));
  assign slot_last  = (CW'(slot) == count - CW'(1));

  always_ff @(posedge clk_2) begin
    if (!reset && wr_ok) begin
      msg_buf[count[IW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      slot      <= '0;
      idx       <= '0;
      code_out  <= CODE_W'(BLANK);
      busy      <= 1'b0;
      done      <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        count     <= '0;
        slot      <= '0;
        idx       <= '0;
        code_out  <= CODE_W'(BLANK);
        busy      <= 1'b0;
        dwell_cnt <= '0;
      end else if (stop && (state != IDLE)) begin
        state     <= IDLE;
        slot      <= '0;
        idx       <= '0;
        code_out  <= CODE_W'(BLANK);
        busy      <= 1'b0;
        dwell_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (wr_ok) begin
              count <= count + CW'(1);
            end
            // An empty buffer with a same-cycle write plays the code being written.
            if (start && ((count != '0) || wr_ok)) begin
              state     <= SHOW;
              slot      <= '0;
              idx       <= '0;
              code_out  <= (count == '0) ? wr_data : msg_buf[0];
              busy      <= 1'b1;
              dwell_cnt <= '0;
            end
          end
          SHOW: begin
            if (dwell_last) begin
              dwell_cnt <= '0;
              idx       <= '0;
              code_out  <= CODE_W'(BLANK);
              if (!slot_last) begin
                state <= GAP;
                slot  <= slot + IW'(1);
              end else begin
`ifdef SEG_MSG_LOOP_EN
                state <= GAP;
                slot  <= '0;
`else
                state <= IDLE;
                slot  <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
`endif
              end
            end else begin
              dwell_cnt <= dwell_cnt + DW'(1);
            end
          end
          GAP: begin
            state     <= SHOW;
            idx       <= slot;
            code_out  <= msg_buf[slot];
            dwell_cnt <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_msg_sequencer.sv
// Bench for seg_msg_sequencer (DEPTH=4, DWELL=3): vector table, directed corner cases, random vs. model.
module tb_seg_msg_sequencer;

  localparam int D = 4;
  localparam int W = 3;

  logic       clk_2 = 1'b0;
  logic       reset, clear, wr_en, start, stop;
  logic [5:0] wr_data;
  logic [5:0] code_out;
  logic [1:0] idx;
  logic       busy, full, done;
  logic [2:0] count;

  int n_vec = 0;
  int n_err = 0;

  seg_msg_sequencer #(.DEPTH(D), .DWELL(W), .CODE_W(6), .BLANK(63)) dut (
    .clk_2(clk_2), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .start(start), .stop(stop), .code_out(code_out), .idx(idx), .busy(busy),
    .full(full), .count(count), .done(done)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    logic       rst, clr, stp, we;
    logic [5:0] wd;
    logic       st;
    logic [5:0] e_code;
    logic       e_busy, e_done;
    logic [2:0] e_cnt;
    logic       e_full;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, clr, stp, we, input logic [5:0] wd, input logic st,
                     input logic [5:0] ec, input logic eb, ed, input logic [2:0] en, input logic ef);
    vec_t v;
    v.rst = rst; v.clr = clr; v.stp = stp; v.we = we; v.wd = wd; v.st = st;
    v.e_code = ec; v.e_busy = eb; v.e_done = ed; v.e_cnt = en; v.e_full = ef;
    tbl.push_back(v);
  endtask

  task automatic add_run(input logic [5:0] c, input int n, input logic [2:0] en, input logic ef);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 6'd0, 0, c, 1, 0, en, ef);
  endtask

  task automatic add_gap(input logic [2:0] en, input logic ef);
    add(0, 0, 0, 0, 6'd0, 0, 6'd63, 1, 0, en, ef);
  endtask

  task automatic add_end(input logic [5:0] first, input logic [2:0] en, input logic ef);
`ifdef SEG_MSG_LOOP_EN
    add_gap(en, ef);
    add_run(first, 1, en, ef);
`else
    add(0, 0, 0, 0, 6'd0, 0, 6'd63, 0, 1, en, ef);
    add(0, 0, 0, 0, 6'd0, 0, 6'd63, 0, 0, en, ef);
`endif
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick(input logic rst, clr, stp, we, input logic [5:0] wd, input logic st);
    reset = rst; clear = clr; stop = stp; wr_en = we; wr_data = wd; start = st;
    @(posedge clk_2);
    #1;
  endtask

  task automatic expect_all(input string nm, input int c, i, b, dn, n);
    chk({nm, ".code"}, int'(code_out), c);
    chk({nm, ".idx"}, int'(idx), i);
    chk({nm, ".busy"}, int'(busy), b);
    chk({nm, ".done"}, int'(done), dn);
    chk({nm, ".count"}, int'(count), n);
  endtask

  // Reference model: playback described by offset since start and the slot/dwell arithmetic.
  int         m_cnt, m_off;
  bit         m_play, m_done;
  logic [5:0] m_q [D];

  task automatic model_step(input logic rst, clr, stp, we, input logic [5:0] wd, input logic st);
    m_done = 0;
    if (rst || clr) begin
      m_play = 0; m_cnt = 0;
    end else if (stp && m_play) begin
      m_play = 0;
    end else if (!m_play) begin
      if (we && m_cnt < D) begin m_q[m_cnt] = wd; m_cnt++; end
      if (st && m_cnt > 0) begin m_play = 1; m_off = 1; end
    end else begin
      m_off++;
`ifndef SEG_MSG_LOOP_EN
      if (m_off >= m_cnt * (W + 1)) begin m_play = 0; m_done = 1; end
`endif
    end
  endtask

  task automatic model_check(input int cyc);
    int p, s, ph, e_code, e_idx;
    e_code = 63; e_idx = 0;
    if (m_play) begin
      p  = (m_off - 1) % (m_cnt * (W + 1));
      s  = p / (W + 1);
      ph = p % (W + 1);
      if (ph < W) begin e_code = int'(m_q[s]); e_idx = s; end
    end
    expect_all($sformatf("rand[%0d]", cyc), e_code, e_idx, int'(m_play), int'(m_done), m_cnt);
    chk($sformatf("rand[%0d].full", cyc), int'(full), int'(m_cnt == D));
  endtask

  initial begin
    reset = 1; clear = 0; stop = 0; wr_en = 0; wr_data = 0; start = 0;

    // Test plan 1: three codes, single pass
    add(1, 0, 0, 0, 6'd0, 0, 6'd63, 0, 0, 3'd0, 0);
    add(0, 0, 0, 1, 6'd1, 0, 6'd63, 0, 0, 3'd1, 0);
    add(0, 0, 0, 1, 6'd2, 0, 6'd63, 0, 0, 3'd2, 0);
    add(0, 0, 0, 1, 6'd3, 0, 6'd63, 0, 0, 3'd3, 0);
    add(0, 0, 0, 0, 6'd0, 1, 6'd1, 1, 0, 3'd3, 0);
    add_run(6'd1, W - 1, 3'd3, 0); add_gap(3'd3, 0);
    add_run(6'd2, W, 3'd3, 0);     add_gap(3'd3, 0);
    add_run(6'd3, W, 3'd3, 0);
    add_end(6'd1, 3'd3, 0);
    // Test plan 2: fifth write discarded once full
    add(1, 0, 0, 0, 6'd0, 0, 6'd63, 0, 0, 3'd0, 0);
    add(0, 0, 0, 1, 6'd7, 0, 6'd63, 0, 0, 3'd1, 0);
    add(0, 0, 0, 1, 6'd8, 0, 6'd63, 0, 0, 3'd2, 0);
    add(0, 0, 0, 1, 6'd9, 0, 6'd63, 0, 0, 3'd3, 0);
    add(0, 0, 0, 1, 6'd10, 0, 6'd63, 0, 0, 3'd4, 1);
    add(0, 0, 0, 1, 6'd11, 0, 6'd63, 0, 0, 3'd4, 1);
    add(0, 0, 0, 0, 6'd0, 1, 6'd7, 1, 0, 3'd4, 1);
    add_run(6'd7, W - 1, 3'd4, 1); add_gap(3'd4, 1);
    add_run(6'd8, W, 3'd4, 1);     add_gap(3'd4, 1);
    add_run(6'd9, W, 3'd4, 1);     add_gap(3'd4, 1);
    add_run(6'd10, W, 3'd4, 1);
    add_end(6'd7, 3'd4, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].rst, tbl[i].clr, tbl[i].stp, tbl[i].we, tbl[i].wd, tbl[i].st);
      chk($sformatf("tbl[%0d].code", i), int'(code_out), int'(tbl[i].e_code));
      chk($sformatf("tbl[%0d].busy", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("tbl[%0d].done", i), int'(done), int'(tbl[i].e_done));
      chk($sformatf("tbl[%0d].count", i), int'(count), int'(tbl[i].e_cnt));
      chk($sformatf("tbl[%0d].full", i), int'(full), int'(tbl[i].e_full));
    end

    // Test plan 3: start on empty buffer
    tick(1, 0, 0, 0, 0, 0);
    expect_all("empty.reset", 63, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    expect_all("empty.start", 63, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, 0, 0);
      expect_all("empty.wait", 63, 0, 0, 0, 0);
    end

    // Test plan 4: stop on 2nd cycle of slot 1, then restart
    tick(0, 0, 0, 1, 6'd4, 0);
    tick(0, 0, 0, 1, 6'd5, 0);
    tick(0, 0, 0, 0, 0, 1);
    expect_all("stop.s0", 4, 0, 1, 0, 2);
    tick(0, 0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    expect_all("stop.gap", 63, 0, 1, 0, 2);
    tick(0, 0, 0, 0, 0, 0);
    expect_all("stop.s1a", 5, 1, 1, 0, 2);
    tick(0, 0, 0, 0, 0, 0);
    expect_all("stop.s1b", 5, 1, 1, 0, 2);
    tick(0, 0, 1, 0, 0, 0);
    expect_all("stop.idle", 63, 0, 0, 0, 2);
    tick(0, 0, 0, 0, 0, 0);
    expect_all("stop.hold", 63, 0, 0, 0, 2);
    tick(0, 0, 0, 0, 0, 1);
    expect_all("stop.restart", 4, 0, 1, 0, 2);

    // Test plan 5: write ignored mid-play, clear mid-play, reset during GAP
    tick(0, 0, 0, 1, 6'd9, 0);
    expect_all("mid.wr", 4, 0, 1, 0, 2);
    tick(0, 1, 0, 0, 0, 0);
    expect_all("mid.clear", 63, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 6'd1, 0);
    tick(0, 0, 0, 1, 6'd2, 1);
    expect_all("wrstart", 1, 0, 1, 0, 2);
    tick(0, 0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    expect_all("rgap.gap", 63, 0, 1, 0, 2);
    tick(1, 0, 0, 0, 0, 0);
    expect_all("rgap.reset", 63, 0, 0, 0, 0);
    chk("rgap.full", int'(full), 0);

    // Test plan 6: single code; loops forever when built with the loop option
    tick(0, 0, 0, 1, 6'd6, 0);
    tick(0, 0, 0, 0, 0, 1);
    chk("one.first", int'(code_out), 6);
    for (int i = 1; i < 24; i++) begin
      tick(0, 0, 0, 0, 0, 0);
`ifdef SEG_MSG_LOOP_EN
      chk($sformatf("loop[%0d].code", i), int'(code_out), ((i % (W + 1)) < W) ? 6 : 63);
      chk($sformatf("loop[%0d].done", i), int'(done), 0);
`else
      chk($sformatf("one[%0d].code", i), int'(code_out), (i < W) ? 6 : 63);
      chk($sformatf("one[%0d].done", i), int'(done), (i == W) ? 1 : 0);
      chk($sformatf("one[%0d].busy", i), int'(busy), (i < W) ? 1 : 0);
`endif
    end

    // Randomized run against the reference model
    tick(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    model_check(0);
    for (int c = 1; c < 3000; c++) begin
      logic rr, cc, ss, ww, st;
      logic [5:0] dd;
      rr = ($urandom_range(0, 199) == 0);
      cc = ($urandom_range(0, 59) == 0);
      ss = ($urandom_range(0, 39) == 0);
      ww = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 7) == 0);
      dd = 6'($urandom);
      model_step(rr, cc, ss, ww, dd, st);
      tick(rr, cc, ss, ww, dd, st);
      model_check(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
